// File: rtl/ds_neuro_pkg.sv
// ds_neuro_pkg: shared defaults and saturation constant for the synaptic datapath
package ds_neuro_pkg;
    localparam int DW_DEF    = 14;
    localparam int N_SYN_DEF = 4;
    localparam logic [DW_DEF-1:0] SYN_MAX = '1;
endpackage

// File: rtl/ds_rr_arbiter.sv
// ds_rr_arbiter: one-hot round-robin grant starting the search at rr_ptr
module ds_rr_arbiter #(
    parameter int N = 4,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [AW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [AW-1:0] index,
    output logic          valid
);
    logic [AW-1:0] idx;
    always_comb begin
        idx   = '0;
        index = '0;
        valid = 1'b0;
        // Scan farthest-first so the hit closest to rr_ptr is the one that sticks
        for (int k = N - 1; k >= 0; k--) begin
            idx = rr_ptr + AW'(k);
            if (pending[idx]) begin
                index = idx;
                valid = 1'b1;
            end
        end
        grant = valid ? (N'(1) << index) : '0;
    end
endmodule

// File: rtl/ds_syn_integrator.sv
// ds_syn_integrator: arbitrated weight injection into a decaying, saturating synaptic current
module ds_syn_integrator
    import ds_neuro_pkg::*;
#(
    parameter int N_SYN = N_SYN_DEF,
    parameter int DW    = DW_DEF,
    localparam int AW   = $clog2(N_SYN)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_SYN-1:0] pre_spike,
    input  logic [DW-1:0]    decay,
    input  logic             w_we,
    input  logic [AW-1:0]    w_addr,
    input  logic [DW-1:0]    w_data,
    input  logic             clr_flags,
    output logic [DW-1:0]    syn_o,
    output logic             sat_o,
    output logic             drop_o
);
    logic [N_SYN-1:0] pending, grant;
    logic [AW-1:0]    rr_ptr, idx;
    logic             valid;
    logic [DW-1:0]    weight [N_SYN];
    logic [2*DW-1:0]  prod;
    logic [DW:0]      sum;
    logic [DW-1:0]    syn_next;
    logic             sat_set, drop_set;

    ds_rr_arbiter #(.N(N_SYN)) u_arb (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .index   (idx),
        .valid   (valid)
    );

    always_comb begin
        prod     = {{DW{1'b0}}, syn_o} * {{DW{1'b0}}, decay};
        sum      = {1'b0, prod[2*DW-1:DW]} + (valid ? {1'b0, weight[idx]} : '0);
        sat_set  = sum[DW];
        syn_next = sat_set ? DW'(SYN_MAX) | {DW{1'b1}} : sum[DW-1:0];
        drop_set = |(pre_spike & pending & ~grant);
    end

    // Weight read above sees the pre-edge value, so a same-index write lands afterwards
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            syn_o   <= '0;
            sat_o   <= 1'b0;
            drop_o  <= 1'b0;
            pending <= '0;
            rr_ptr  <= '0;
            weight  <= '{default: '0};
        end else begin
            syn_o   <= syn_next;
            sat_o   <= sat_set | (sat_o & ~clr_flags);
            drop_o  <= drop_set | (drop_o & ~clr_flags);
            pending <= (pending & ~grant) | pre_spike;
            if (valid) rr_ptr <= idx + AW'(1);
            if (w_we) weight[w_addr] <= w_data;
        end
    end
endmodule
